// File: rtl/lstm_pkg.sv
// lstm_pkg: shared data width, gate index and scheduler types for the LSTM activation path
package lstm_pkg;
    localparam int DWIDTH = 16;
    typedef enum logic [1:0] {GATE_I, GATE_F, GATE_O} gate_t;
    typedef enum logic {IDLE, BURST} state_t;
    typedef struct packed {
        logic  valid;
        gate_t tag;
        logic  last;
    } side_t;
endpackage

// File: rtl/sigmoid.sv
// sigmoid: piecewise-linear Q8.8 logistic function with LAT register stages
module sigmoid #(
    parameter int DWIDTH = 16,
    parameter int LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DWIDTH-1:0] x,
    output logic [DWIDTH-1:0] y
);
    logic [DWIDTH:0]   a;
    logic [8:0]        m;
    logic [DWIDTH-1:0] pipe [LAT];
    // |x| carries one extra bit so the most negative input cannot overflow
    assign a = x[DWIDTH-1] ? {1'b0, ~x} + 1'b1 : {1'b0, x};
    assign m = a >= 17'd1280 ? 9'd256 :
               a >= 17'd608  ? 9'(a >> 5) + 9'd216 :
               a >= 17'd256  ? 9'(a >> 3) + 9'd160 :
                               9'(a >> 2) + 9'd128;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int i = 0; i < LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= x[DWIDTH-1] ? DWIDTH'(9'd256 - m) : DWIDTH'(m);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    assign y = pipe[LAT-1];
endmodule

// File: rtl/gate_act_sched.sv
// gate_act_sched: burst-locked round-robin sharing of one sigmoid among the LSTM gates
module gate_act_sched #(
    parameter int DWIDTH = lstm_pkg::DWIDTH,
    parameter int NREQ = 3,
    parameter int SIG_LAT = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NREQ-1:0]             req_valid,
    input  logic [NREQ-1:0]             req_last,
    input  logic [NREQ-1:0][DWIDTH-1:0] req_data,
    output logic [NREQ-1:0]             req_ready,
    output logic                        res_valid,
    output logic [DWIDTH-1:0]           res_data,
    output logic [1:0]                  res_tag,
    output logic                        res_last,
    output logic                        busy
);
    import lstm_pkg::*;
    localparam int CW = $clog2(SIG_LAT + 2);
    state_t            st, st_n;
    gate_t             g, g_n, ptr, ptr_n, pick;
    logic [CW-1:0]     cnt;
    logic [DWIDTH-1:0] x, y;
    side_t             sb [SIG_LAT+1];
    logic              issue;
    assign issue = st == BURST && req_valid[g];
    // lowest offset from ptr wins, so scan from the far end down
    always_comb begin
        pick = ptr;
        for (int i = NREQ - 1; i >= 0; i--)
            if (req_valid[(int'(ptr) + i) % NREQ]) pick = gate_t'((int'(ptr) + i) % NREQ);
    end
    always_comb begin
        st_n = st;
        g_n = g;
        ptr_n = ptr;
        if (st == IDLE && |req_valid) begin
            st_n = BURST;
            g_n = pick;
        end
        if (issue && req_last[g]) begin
            st_n = IDLE;
            ptr_n = gate_t'((int'(g) + 1) % NREQ);
        end
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            st <= IDLE;
            ptr <= GATE_I;
            g <= GATE_I;
            cnt <= '0;
            x <= '0;
            for (int i = 0; i <= SIG_LAT; i++) sb[i] <= side_t'('0);
        end else begin
            st <= st_n;
            ptr <= ptr_n;
            g <= g_n;
            cnt <= cnt + CW'(issue) - CW'(res_valid);
            if (issue) x <= req_data[g];
            sb[0] <= issue ? side_t'{1'b1, g, req_last[g]} : side_t'('0);
            for (int i = 1; i <= SIG_LAT; i++) sb[i] <= sb[i-1];
        end
    sigmoid #(.DWIDTH(DWIDTH), .LAT(SIG_LAT)) u_sig (.clk(clk), .rst(rst), .x(x), .y(y));
    assign req_ready = st == BURST ? NREQ'(1) << g : '0;
    assign res_valid = sb[SIG_LAT].valid;
    assign res_tag   = sb[SIG_LAT].tag;
    assign res_last  = sb[SIG_LAT].last;
    assign res_data  = res_valid ? y : '0;
    assign busy      = st == BURST || cnt != '0;
endmodule

// File: tb/tb_gate_act_sched.sv
// tb_gate_act_sched: random and directed stimulus against a behavioural scheduler/sigmoid model
module tb_gate_act_sched;
    localparam int NREQ = 3, SIG_LAT = 2, DW = 16;
    logic clk = 0, rst = 1;
    logic [NREQ-1:0] req_valid = '0, req_last = '0, req_ready;
    logic [NREQ-1:0][DW-1:0] req_data = '0;
    logic res_valid, res_last, busy;
    logic [DW-1:0] res_data;
    logic [1:0] res_tag;

    gate_act_sched #(.DWIDTH(DW), .NREQ(NREQ), .SIG_LAT(SIG_LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready), .res_valid(res_valid), .res_data(res_data), .res_tag(res_tag),
        .res_last(res_last), .busy(busy));

    always #5 clk = ~clk;

    typedef struct {int due; int data; int tag; int last;} exp_t;
    exp_t pend[$];
    int n_cmp = 0, n_bad = 0, cyc = 0;
    bit m_burst = 0;
    int m_g = 0, m_ptr = 0, ev, k;
    logic [NREQ-1:0] hs = '0, er;
    int log_tag[$], log_last[$], log_data[$], log_cyc[$], acc_cyc[$];
    int left[NREQ], hold[NREQ];
    bit zero_data = 0;

    function automatic int sig_ref(logic [15:0] x);
        int xi;
        real v, a, y;
        xi = $signed(x);
        v = real'(xi) / 256.0;
        a = v < 0.0 ? -v : v;
        y = a >= 5.0 ? 1.0 : a >= 2.375 ? a / 32.0 + 0.84375 : a >= 1.0 ? a / 8.0 + 0.625 : a / 4.0 + 0.5;
        return v < 0.0 ? 256 - int'($floor(y * 256.0)) : int'($floor(y * 256.0));
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        hs = req_valid & req_ready;
        if (rst) begin
            chk("rst_ready", req_ready, 0);
            chk("rst_res_valid", res_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_res_data", res_data, 0);
            m_burst = 0; m_g = 0; m_ptr = 0;
            pend.delete();
            hs = '0;
        end else begin
            er = m_burst ? 3'(1 << m_g) : 3'b0;
            ev = (pend.size() > 0 && pend[0].due == cyc) ? 1 : 0;
            chk("ready", req_ready, er);
            chk("busy", busy, (m_burst || pend.size() > 0) ? 1 : 0);
            chk("res_valid", res_valid, ev);
            if (ev == 1) begin
                chk("res_data", res_data, pend[0].data);
                chk("res_tag", res_tag, pend[0].tag);
                chk("res_last", res_last, pend[0].last);
                void'(pend.pop_front());
            end else begin
                chk("idle_tag", res_tag, 0);
                chk("idle_last", res_last, 0);
            end
            if (res_valid) begin
                log_tag.push_back(res_tag); log_last.push_back(res_last);
                log_data.push_back(res_data); log_cyc.push_back(cyc);
            end
            if (hs != 0) acc_cyc.push_back(cyc);
            if (!m_burst) begin
                if (req_valid != 0) begin
                    k = m_ptr;
                    while (!req_valid[k]) k = (k + 1) % NREQ;
                    m_g = k;
                    m_burst = 1;
                end
            end else if (req_valid[m_g]) begin
                pend.push_back('{cyc + SIG_LAT + 1, sig_ref(req_data[m_g]), m_g, int'(req_last[m_g])});
                if (req_last[m_g]) begin
                    m_ptr = (m_g + 1) % NREQ;
                    m_burst = 0;
                end
            end
        end
        cyc++;
    end

    task automatic clr();
        log_tag.delete(); log_last.delete(); log_data.delete(); log_cyc.delete(); acc_cyc.delete();
    endtask

    task automatic step();
        @(posedge clk); #1;
        for (int i = 0; i < NREQ; i++) begin
            if (hs[i] && left[i] > 0) left[i]--;
            req_valid[i] = left[i] > 0 && hold[i] == 0;
            req_last[i] = left[i] == 1;
            req_data[i] = zero_data ? 16'h0 : 16'($urandom);
            if (hold[i] > 0) hold[i]--;
        end
    endtask

    task automatic do_reset();
        rst = 1;
        req_valid = '0; req_last = '0;
        for (int i = 0; i < NREQ; i++) begin left[i] = 0; hold[i] = 0; end
        repeat (2) @(posedge clk);
        #1 rst = 0;
        clr();
    endtask

    task automatic wait_idle();
        int t = 0;
        do begin step(); t++; end while ((left.sum() != 0 || busy || req_valid != 0) && t < 300);
        if (t >= 300) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_idle timeout cyc=%0d got=busy want=idle", cyc);
        end
    endtask

    task automatic chk_tags(string nm, int n, int code);
        chk({nm, "_count"}, log_tag.size(), n);
        for (int i = 0; i < n && i < log_tag.size(); i++) chk(nm, log_tag[i], (code >> (4 * (n - 1 - i))) & 15);
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin left[i] = 0; hold[i] = 0; end
        repeat (3) @(posedge clk);
        #1 rst = 0;
        clr();
        zero_data = 1;
        left[0] = 4;
        wait_idle();
        chk_tags("a_tags", 4, 'h0000);
        for (int i = 0; i < 4 && i < log_data.size(); i++) begin
            chk("a_data", log_data[i], 'h80);
            chk("a_last", log_last[i], i == 3 ? 1 : 0);
        end
        if (log_cyc.size() > 0 && acc_cyc.size() > 0) chk("a_latency", log_cyc[0] - acc_cyc[0], SIG_LAT + 1);
        zero_data = 0;
        do_reset();
        for (int i = 0; i < NREQ; i++) left[i] = 2;
        wait_idle();
        chk_tags("b_rr", 6, 'h001122);
        clr();
        left[0] = 2; left[2] = 2;
        wait_idle();
        chk_tags("b_wrap", 4, 'h0022);
        do_reset();
        left[1] = 4;
        repeat (3) step();
        hold[1] = 3; left[0] = 2;
        wait_idle();
        chk_tags("c_hold", 6, 'h111100);
        if (log_cyc.size() >= 4) chk("c_gap", log_cyc[3] - log_cyc[0] - 3, 3);
        do_reset();
        left[2] = 5;
        repeat (4) step();
        do_reset();
        repeat (8) step();
        chk("d_quiet", log_tag.size(), 0);
        left[0] = 1; left[2] = 1;
        wait_idle();
        chk_tags("d_next", 2, 'h02);
        clr();
        left[0] = 2; left[1] = 2;
        wait_idle();
        chk_tags("e_b2b", 4, 'h0011);
        if (acc_cyc.size() >= 3) chk("e_gap", acc_cyc[2] - acc_cyc[1], 2);
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (left[i] == 0 && $urandom_range(3) == 0) left[i] = $urandom_range(5, 1);
                if (hold[i] == 0 && $urandom_range(7) == 0) hold[i] = $urandom_range(3, 1);
            end
            step();
        end
        wait_idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
        $fatal(1, "watchdog");
    end
endmodule
